// File: rtl/mult_stage_ctrl.sv
// Sequencer for the multiplier_stage lane array: serial lane load, serial signed reduction, valid/ready result.
// Define MULT_CTRL_SAT_EN for saturating accumulation; the default build wraps modulo 2^ACC_W.
module mult_stage_ctrl #(
  parameter int N_STAGE = 5,
  parameter int ACC_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_w,
  input  logic                        in_x,
  input  logic                        acc_clr,
  output logic [(2**N_STAGE)-1:0]     w_bus,
  output logic [(2**N_STAGE)-1:0]     x_bus,
  input  logic [2*(2**N_STAGE)-1:0]   mult_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_W-1:0]     out_sum,
  output logic                        busy
);

  localparam int N = 2**N_STAGE;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_SUM  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [N_STAGE-1:0] CNT_LAST = '1;

  logic [1:0]         state_q, state_d;
  logic [N_STAGE-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [N-1:0]       w_q, w_d;
  logic [N-1:0]       x_q, x_d;
  logic               out_valid_q, out_valid_d;

  logic [1:0]         lane;
  logic [ACC_W-1:0]   lane_ext;
  logic [ACC_W-1:0]   add_result;

  // The lane under reduction is picked by cnt; its product is a 2-bit signed value.
  assign lane     = mult_out[{cnt_q, 1'b0} +: 2];
  assign lane_ext = {{(ACC_W-2){lane[1]}}, lane};

`ifdef MULT_CTRL_SAT_EN
  logic [ACC_W:0] sum_wide;
  logic           sum_ovf;

  // One guard bit exposes signed overflow; clamp toward the rail of the true result's sign.
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {lane_ext[ACC_W-1], lane_ext};
  assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  always_comb begin
    add_result = sum_wide[ACC_W-1:0];
    if (sum_ovf) begin
      add_result = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign add_result = acc_q + lane_ext;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    w_d         = w_q;
    x_d         = x_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          w_d[cnt_q] = in_w;
          x_d[cnt_q] = in_x;
          if (cnt_q == '0 && acc_clr) begin
            acc_d = '0;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_SUM;
            cnt_d   = '0;
          end
        end
      end
      ST_SUM: begin
        acc_d = add_result;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_OUT;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d     = ST_LOAD;
          out_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d     = ST_LOAD;
        out_valid_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      acc_q       <= '0;
      w_q         <= '0;
      x_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      w_q         <= w_d;
      x_q         <= x_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_SUM) || (state_q == ST_OUT);
  assign w_bus     = w_q;
  assign x_bus     = x_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;

endmodule
